// File: rtl/rotor_stepper_pkg.sv
// Shared definitions for the rotor stepper: rotor ids, notch letters, FSM states.
// The optional step counter is enabled with the STEP_COUNT_EN macro (see rotor_stepper.sv).
package rotor_stepper_pkg;

  localparam int POS_W     = 5;
  localparam int N_LETTERS = 26;

  localparam logic [2:0] ROTOR_I   = 3'd0;
  localparam logic [2:0] ROTOR_II  = 3'd1;
  localparam logic [2:0] ROTOR_III = 3'd2;
  localparam logic [2:0] ROTOR_IV  = 3'd3;
  localparam logic [2:0] ROTOR_V   = 3'd4;

  localparam logic [POS_W-1:0] NOTCH_I   = 5'd16;
  localparam logic [POS_W-1:0] NOTCH_II  = 5'd4;
  localparam logic [POS_W-1:0] NOTCH_III = 5'd21;
  localparam logic [POS_W-1:0] NOTCH_IV  = 5'd9;
  localparam logic [POS_W-1:0] NOTCH_V   = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] pos;
  } notch_t;

  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
    if (p == 5'(N_LETTERS - 1)) begin
      return {POS_W{1'b0}};
    end else begin
      return p + 5'd1;
    end
  endfunction

endpackage

// File: rtl/rotor_stepper_if.sv
// Control/status bundle between config_manager (master) and rotor_stepper (slave).
interface rotor_stepper_if;
  import rotor_stepper_pkg::*;

  logic [2:0]       rotor_sel_l;
  logic [2:0]       rotor_sel_m;
  logic [2:0]       rotor_sel_r;
  logic [POS_W-1:0] grundstellung_l;
  logic [POS_W-1:0] grundstellung_m;
  logic [POS_W-1:0] grundstellung_r;
  logic             load;
  logic             step_req;
  logic [POS_W-1:0] pos_l;
  logic [POS_W-1:0] pos_m;
  logic [POS_W-1:0] pos_r;
  logic             busy;
  logic             step_done;
  logic [15:0]      step_count;

  modport master (
    output rotor_sel_l, rotor_sel_m, rotor_sel_r,
    output grundstellung_l, grundstellung_m, grundstellung_r,
    output load, step_req,
    input  pos_l, pos_m, pos_r, busy, step_done, step_count
  );

  modport slave (
    input  rotor_sel_l, rotor_sel_m, rotor_sel_r,
    input  grundstellung_l, grundstellung_m, grundstellung_r,
    input  load, step_req,
    output pos_l, pos_m, pos_r, busy, step_done, step_count
  );

endinterface

// File: rtl/rotor_stepper_notch_lut.sv
// Rotor id -> turnover notch window letter; ids 5..7 carry no notch.
module rotor_stepper_notch_lut
  import rotor_stepper_pkg::*;
(
  input  logic [2:0] rotor_sel_i,
  output notch_t     notch_o
);

  // Notch lookup, purely combinational
  always_comb begin
    notch_o.valid = 1'b0;
    notch_o.pos   = {POS_W{1'b0}};
    case (rotor_sel_i)
      ROTOR_I:   begin notch_o.valid = 1'b1; notch_o.pos = NOTCH_I;   end
      ROTOR_II:  begin notch_o.valid = 1'b1; notch_o.pos = NOTCH_II;  end
      ROTOR_III: begin notch_o.valid = 1'b1; notch_o.pos = NOTCH_III; end
      ROTOR_IV:  begin notch_o.valid = 1'b1; notch_o.pos = NOTCH_IV;  end
      ROTOR_V:   begin notch_o.valid = 1'b1; notch_o.pos = NOTCH_V;   end
      default:   begin notch_o.valid = 1'b0; notch_o.pos = {POS_W{1'b0}}; end
    endcase
  end

endmodule

// File: rtl/rotor_stepper.sv
// Live rotor positions with Enigma I stepping (including double step), load/step FSM.
// Define STEP_COUNT_EN to build the 16-bit keystroke counter; otherwise step_count is 0.
module rotor_stepper
  import rotor_stepper_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  rotor_stepper_if.slave  bus
);

  state_e           state_q;
  logic [POS_W-1:0] pos_l_q, pos_m_q, pos_r_q;
  logic [POS_W-1:0] pos_l_d, pos_m_d, pos_r_d;
  logic             busy_q;
  logic             step_done_q;
  notch_t           notch_m_s, notch_r_s;
  logic             r_at_s, m_at_s;

  // The left rotor's notch never moves anything in a three-rotor machine, so only
  // the middle and right rotors need a lookup.
  rotor_stepper_notch_lut u_notch_m (.rotor_sel_i(bus.rotor_sel_m), .notch_o(notch_m_s));
  rotor_stepper_notch_lut u_notch_r (.rotor_sel_i(bus.rotor_sel_r), .notch_o(notch_r_s));

  // Next positions from the pre-step window letters
  always_comb begin
    r_at_s  = notch_r_s.valid && (pos_r_q == notch_r_s.pos);
    m_at_s  = notch_m_s.valid && (pos_m_q == notch_m_s.pos);
    pos_r_d = pos_inc(pos_r_q);
    if (r_at_s || m_at_s) begin
      pos_m_d = pos_inc(pos_m_q);
    end else begin
      pos_m_d = pos_m_q;
    end
    if (m_at_s) begin
      pos_l_d = pos_inc(pos_l_q);
    end else begin
      pos_l_d = pos_l_q;
    end
  end

  // Step FSM; load and step requests are only honoured in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pos_l_q     <= {POS_W{1'b0}};
      pos_m_q     <= {POS_W{1'b0}};
      pos_r_q     <= {POS_W{1'b0}};
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          step_done_q <= 1'b0;
          if (bus.load) begin
            pos_l_q <= bus.grundstellung_l;
            pos_m_q <= bus.grundstellung_m;
            pos_r_q <= bus.grundstellung_r;
            busy_q  <= 1'b0;
          end else if (bus.step_req) begin
            state_q <= ST_UPDATE;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_UPDATE: begin
          pos_l_q     <= pos_l_d;
          pos_m_q     <= pos_m_d;
          pos_r_q     <= pos_r_d;
          state_q     <= ST_DONE;
          busy_q      <= 1'b1;
          step_done_q <= 1'b1;
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          step_done_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          step_done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef STEP_COUNT_EN
  logic [15:0] step_count_q;

  // Keystroke counter: +1 per UPDATE, cleared by an accepted load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count_q <= 16'd0;
    end else if (state_q == ST_UPDATE) begin
      step_count_q <= step_count_q + 16'd1;
    end else if ((state_q == ST_IDLE) && bus.load) begin
      step_count_q <= 16'd0;
    end else begin
      step_count_q <= step_count_q;
    end
  end

  assign bus.step_count = step_count_q;
`else
  assign bus.step_count = 16'd0;
`endif

  assign bus.pos_l     = pos_l_q;
  assign bus.pos_m     = pos_m_q;
  assign bus.pos_r     = pos_r_q;
  assign bus.busy      = busy_q;
  assign bus.step_done = step_done_q;

endmodule
